// File: rtl/fifo_wr_arbiter_if.sv
// Requester/FIFO-side bundle for fifo_wr_arbiter: per-requester handshake, FIFO write port,
// FIFO status flags and arbiter status outputs.
interface fifo_wr_arbiter_if #(
    parameter int unsigned FIFO_WIDTH = 16,
    parameter int unsigned NUM_REQ    = 4
);
    localparam int unsigned IdW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*FIFO_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ-1:0]            req_ready;

    logic [FIFO_WIDTH-1:0]         fifo_data_in;
    logic                          fifo_wr_en;
    logic                          fifo_full;
    logic                          fifo_almostfull;
    logic                          fifo_wr_ack;
    logic                          fifo_overflow;

    logic [IdW-1:0]                grant_id;
    logic                          locked;
    logic                          ack_err;
    logic [15:0]                   wr_count;

    // Arbiter side
    modport slave (
        input  req_valid, req_data, req_last,
        input  fifo_full, fifo_almostfull, fifo_wr_ack, fifo_overflow,
        output req_ready, fifo_data_in, fifo_wr_en,
        output grant_id, locked, ack_err, wr_count
    );

    // Requesters and FIFO side
    modport master (
        output req_valid, req_data, req_last,
        output fifo_full, fifo_almostfull, fifo_wr_ack, fifo_overflow,
        input  req_ready, fifo_data_in, fifo_wr_en,
        input  grant_id, locked, ack_err, wr_count
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter merging NUM_REQ burst requesters into one FIFO write port, with burst
// locking, registered FIFO write strobe, write-acknowledge checking and a saturating ack counter.
module fifo_wr_arbiter #(
    parameter int unsigned FIFO_WIDTH = 16,
    parameter int unsigned NUM_REQ    = 4
) (
    input  logic               clk,
    input  logic               rst,
    fifo_wr_arbiter_if.slave   bus
);
    localparam int unsigned IdW = $clog2(NUM_REQ);

    typedef enum logic [0:0] {
        StIdle,
        StLocked
    } state_e;

    state_e                r_state, w_state_nxt;
    logic [IdW-1:0]        r_rr_ptr, w_rr_ptr_nxt;
    logic [IdW-1:0]        r_lock_id, w_lock_id_nxt;

    logic                  r_wr_en;
    logic [FIFO_WIDTH-1:0] r_data;
    logic [IdW-1:0]        r_grant_id;
    logic                  r_pend;
    logic                  r_ack_err;
    logic [15:0]           r_wr_count;

    logic                  w_space_ok;
    logic [IdW-1:0]        w_sel;
    logic                  w_sel_vld;
    logic [IdW-1:0]        w_gnt_id;
    logic                  w_gnt_vld;
    logic [NUM_REQ-1:0]    w_ready;
    logic                  w_xfer;
    logic [IdW-1:0]        w_gnt_inc;

    // An in-flight write into the last free entry must block a new grant.
    assign w_space_ok = !bus.fifo_full && !(bus.fifo_almostfull && r_wr_en);

    // First valid requester at or after rr_ptr; descending loop so the nearest one wins.
    always_comb begin
        int idx;
        w_sel     = '0;
        w_sel_vld = 1'b0;
        for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
            idx = (int'(r_rr_ptr) + k) % int'(NUM_REQ);
            if (bus.req_valid[idx]) begin
                w_sel     = IdW'(idx);
                w_sel_vld = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_rr_ptr_nxt  = r_rr_ptr;
        w_lock_id_nxt = r_lock_id;
        w_gnt_id      = w_sel;
        w_gnt_vld     = w_sel_vld;
        w_ready       = '0;
        w_xfer        = 1'b0;
        w_gnt_inc     = '0;

        unique case (r_state)
            StIdle: begin
                w_gnt_id  = w_sel;
                w_gnt_vld = w_sel_vld;
            end
            StLocked: begin
                w_gnt_id  = r_lock_id;
                w_gnt_vld = 1'b1;
            end
            default: begin
                w_gnt_id  = w_sel;
                w_gnt_vld = 1'b0;
            end
        endcase

        w_ready[w_gnt_id] = w_gnt_vld && w_space_ok && !rst;
        w_xfer            = w_ready[w_gnt_id] && bus.req_valid[w_gnt_id];
        w_gnt_inc         = IdW'((int'(w_gnt_id) + 1) % int'(NUM_REQ));

        if (w_xfer) begin
            if (bus.req_last[w_gnt_id]) begin
                w_state_nxt  = StIdle;
                w_rr_ptr_nxt = w_gnt_inc;
            end else begin
                w_state_nxt   = StLocked;
                w_lock_id_nxt = w_gnt_id;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= StIdle;
            r_rr_ptr  <= '0;
            r_lock_id <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_rr_ptr  <= w_rr_ptr_nxt;
            r_lock_id <= w_lock_id_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_en    <= 1'b0;
            r_data     <= '0;
            r_grant_id <= '0;
        end else if (w_xfer) begin
            r_wr_en    <= 1'b1;
            r_data     <= bus.req_data[int'(w_gnt_id)*FIFO_WIDTH +: FIFO_WIDTH];
            r_grant_id <= w_gnt_id;
        end else begin
            r_wr_en    <= 1'b0;
        end
    end

    // r_pend marks the cycle in which the FIFO must acknowledge the previous write.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend     <= 1'b0;
            r_ack_err  <= 1'b0;
            r_wr_count <= '0;
        end else begin
            r_pend <= r_wr_en;
            if ((r_pend && (!bus.fifo_wr_ack || bus.fifo_overflow)) ||
                (!r_pend && bus.fifo_wr_ack)) begin
                r_ack_err <= 1'b1;
            end
            if (r_pend && bus.fifo_wr_ack && (r_wr_count != 16'hFFFF)) begin
                r_wr_count <= r_wr_count + 16'd1;
            end
        end
    end

    assign bus.req_ready    = w_ready;
    assign bus.fifo_wr_en   = r_wr_en;
    assign bus.fifo_data_in = r_data;
    assign bus.grant_id     = r_grant_id;
    assign bus.locked       = (r_state == StLocked);
    assign bus.ack_err      = r_ack_err;
    assign bus.wr_count     = r_wr_count;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus a random phase, every cycle compared
// against a behavioural model of the arbiter and a depth-8 FIFO.
module tb_fifo_wr_arbiter;
    localparam int W     = 16;
    localparam int N     = 4;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst;

    fifo_wr_arbiter_if #(.FIFO_WIDTH(W), .NUM_REQ(N)) bus ();

    fifo_wr_arbiter #(.FIFO_WIDTH(W), .NUM_REQ(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state
    bit          m_locked;
    int          m_lock_id;
    int          m_rr;
    bit          m_wr_en;
    logic [W-1:0] m_data;
    int          m_gid;
    bit          m_pend;
    bit          m_err;
    int          m_cnt;
    int          f_count;
    bit          drain;
    bit          ack_kill;
    bit          ack_spur;
    int          obs_wr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_rst();
        m_locked  = 1'b0;
        m_lock_id = 0;
        m_rr      = 0;
        m_wr_en   = 1'b0;
        m_data    = '0;
        m_gid     = 0;
        m_pend    = 1'b0;
        m_err     = 1'b0;
        m_cnt     = 0;
    endtask

    function automatic int pick();
        if (m_locked) return m_lock_id;
        for (int k = 0; k < N; k++) begin
            if (bus.req_valid[(m_rr + k) % N]) return (m_rr + k) % N;
        end
        return -1;
    endfunction

    // One clock cycle: called at the falling edge with inputs already set.
    task automatic step();
        int g;
        bit sok, xfer, rd, ack;
        logic [N-1:0] exp_rdy;
        ack = (m_pend && !ack_kill) || ack_spur;
        bus.fifo_full       = (f_count >= DEPTH);
        bus.fifo_almostfull = (f_count >= DEPTH - 1);
        bus.fifo_wr_ack     = ack;
        bus.fifo_overflow   = 1'b0;
        #1;
        sok = (f_count < DEPTH) && !((f_count >= DEPTH - 1) && m_wr_en);
        g = pick();
        exp_rdy = '0;
        if (!rst && g >= 0 && sok) exp_rdy[g] = 1'b1;
        xfer = (g >= 0) && exp_rdy[g] && bus.req_valid[g];
        chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
        @(posedge clk);
        rd = drain && (f_count > 0);
        f_count = f_count + (m_wr_en ? 1 : 0) - (rd ? 1 : 0);
        if (rst) begin
            model_rst();
        end else begin
            if (m_pend && !ack) m_err = 1'b1;
            if (!m_pend && ack) m_err = 1'b1;
            if (m_pend && ack && m_cnt < 65535) m_cnt++;
            m_pend  = m_wr_en;
            m_wr_en = xfer;
            if (xfer) begin
                m_data = bus.req_data[g*W +: W];
                m_gid  = g;
                if (bus.req_last[g]) begin
                    m_locked = 1'b0;
                    m_rr     = (g + 1) % N;
                end else begin
                    m_locked  = 1'b1;
                    m_lock_id = g;
                end
            end
        end
        #1;
        if (bus.fifo_wr_en === 1'b1) obs_wr++;
        chk("fifo_wr_en",   32'(bus.fifo_wr_en),   32'(m_wr_en));
        chk("fifo_data_in", 32'(bus.fifo_data_in), 32'(m_data));
        chk("grant_id",     32'(bus.grant_id),     32'(m_gid));
        chk("locked",       32'(bus.locked),       32'(m_locked));
        chk("ack_err",      32'(bus.ack_err),      32'(m_err));
        chk("wr_count",     32'(bus.wr_count),     32'(m_cnt));
        @(negedge clk);
    endtask

    task automatic reset_cycle();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic set_req(input logic [N-1:0] v, input logic [N-1:0] l);
        bus.req_valid = v;
        bus.req_last  = l;
        bus.req_data  = {$urandom(), $urandom()};
    endtask

    initial begin
        model_rst();
        f_count  = 0;
        drain    = 1'b1;
        ack_kill = 1'b0;
        ack_spur = 1'b0;
        obs_wr   = 0;

        // Reset with all requesters valid: ready must stay low
        rst = 1'b1;
        set_req(4'b1111, 4'b1111);
        step();
        step();
        rst = 1'b0;

        // Single-word bursts from all four: grants rotate 0,1,2,3,0,1
        for (int i = 0; i < 6; i++) begin
            set_req(4'b1111, 4'b1111);
            step();
            chk("rotate_gid", 32'(bus.grant_id), 32'(i % N));
        end

        // Requester 2 burst of 3 while requester 1 waits
        reset_cycle();
        set_req(4'b0010, 4'b0010);
        step();
        set_req(4'b0110, 4'b0010);
        step();
        set_req(4'b0110, 4'b0010);
        step();
        chk("burst_locked", 32'(bus.locked), 32'd1);
        set_req(4'b0110, 4'b0110);
        step();
        chk("burst_end_gid", 32'(bus.grant_id), 32'd2);
        set_req(4'b0010, 4'b0010);
        step();
        chk("after_burst_gid", 32'(bus.grant_id), 32'd1);
        set_req(4'b0000, 4'b0000);
        step();

        // FIFO with 6 of 8 entries, no drain: exactly two writes land
        reset_cycle();
        f_count = 6;
        drain   = 1'b0;
        obs_wr  = 0;
        for (int i = 0; i < 6; i++) begin
            set_req(4'b0001, 4'b0001);
            step();
        end
        chk("writes_into_6of8", 32'(obs_wr), 32'd2);
        set_req(4'b0000, 4'b0000);
        step();
        f_count = 0;
        drain   = 1'b1;

        // Reset while locked to requester 3
        reset_cycle();
        set_req(4'b1000, 4'b0000);
        step();
        set_req(4'b1000, 4'b0000);
        step();
        chk("lock3", 32'(bus.locked), 32'd1);
        rst = 1'b1;
        set_req(4'b1111, 4'b1111);
        step();
        chk("rst_lock_wr_en", 32'(bus.fifo_wr_en), 32'd0);
        chk("rst_lock_locked", 32'(bus.locked), 32'd0);
        rst = 1'b0;
        set_req(4'b1111, 4'b1111);
        step();
        chk("grant_after_reset", 32'(bus.grant_id), 32'd0);

        // Missing write acknowledge sets a sticky error
        reset_cycle();
        set_req(4'b0001, 4'b0001);
        step();
        set_req(4'b0000, 4'b0000);
        step();
        ack_kill = 1'b1;
        step();
        ack_kill = 1'b0;
        repeat (3) step();
        chk("ack_err_sticky", 32'(bus.ack_err), 32'd1);
        chk("ack_err_count", 32'(bus.wr_count), 32'd0);
        reset_cycle();

        // Random traffic with random draining, occasional resets and spurious acks
        for (int i = 0; i < 600; i++) begin
            set_req(N'($urandom()), N'($urandom()));
            drain    = 1'($urandom_range(0, 1));
            ack_spur = ($urandom_range(0, 99) == 0);
            rst      = ($urandom_range(0, 39) == 0);
            step();
        end
        rst      = 1'b0;
        ack_spur = 1'b0;
        drain    = 1'b1;
        f_count  = 0;

        // Saturation of the ack counter
        reset_cycle();
        for (int i = 0; i < 65540; i++) begin
            set_req(4'b0001, 4'b0001);
            step();
        end
        set_req(4'b0000, 4'b0000);
        repeat (3) step();
        chk("wr_count_sat", 32'(bus.wr_count), 32'h0000_FFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 SHALL have parameter FIFO_WIDTH, default 16, meaning the data word width, matching the FIFO data_in width.
REQ-002 SHALL have parameter NUM_REQ, default 4, meaning the number of requesters, legal range 2..8.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on the rising edge.
REQ-004 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-005 SHALL have port req_valid, input, NUM_REQ, per-requester word valid.
REQ-006 SHALL have port req_data, input, NUM_REQ*FIFO_WIDTH, requester i's word in bits [i*FIFO_WIDTH +: FIFO_WIDTH].
REQ-007 SHALL have port req_last, input, NUM_REQ, marking the last word of requester i's burst.
REQ-008 SHALL have port req_ready, output, NUM_REQ, per-requester accept.
REQ-009 SHALL have port fifo_data_in, output, FIFO_WIDTH, a registered word to the FIFO data_in.
REQ-010 SHALL have port fifo_wr_en, output, 1, a registered strobe to the FIFO wr_en.
REQ-011 SHALL have ports fifo_full, fifo_almostfull, fifo_wr_ack and fifo_overflow, each input, 1, driven by the FIFO flags.
REQ-012 SHALL have port grant_id, output, $clog2(NUM_REQ), the index of the current or last granted requester.
REQ-013 SHALL have port locked, output, 1, high while the state is LOCKED.
REQ-014 SHALL have port ack_err, output, 1, a sticky write-acknowledge error flag.
REQ-015 SHALL have port wr_count, output, 16, counting acknowledged writes and saturating at 16'hFFFF.

Function
REQ-016 SHALL define space_ok = !fifo_full && !(fifo_almostfull && fifo_wr_en), so that an in-flight write into the last free entry blocks further grants.
REQ-017 SHALL define transfer(i) = req_valid[i] && req_ready[i]; req_ready SHALL be combinational from state, rr_ptr, req_valid and space_ok, with at most one bit high.
REQ-018 SHALL, in state IDLE, set req_ready[g]=space_ok, where g is the first index with req_valid set, searching from rr_ptr upward modulo NUM_REQ; all other req_ready bits SHALL be 0.
REQ-019 SHALL, on transfer(g) in IDLE: with req_last[g]=1, remain in IDLE and set rr_ptr=(g+1) mod NUM_REQ; with req_last[g]=0, go to LOCKED with lock_id=g.
REQ-020 SHALL, in state LOCKED, set req_ready[lock_id]=space_ok and all other bits to 0.
REQ-021 SHALL stay LOCKED when req_valid[lock_id] drops.
REQ-022 SHALL, on transfer with req_last[lock_id]=1, go to IDLE with rr_ptr=(lock_id+1) mod NUM_REQ.
REQ-023 SHALL, on the edge after transfer(i), set fifo_wr_en=1, fifo_data_in=req_data word i and grant_id=i; with no transfer, fifo_wr_en SHALL be 0 and fifo_data_in SHALL hold its value.
REQ-024 SHALL sustain one word per cycle, with 1-cycle latency from handshake to fifo_wr_en.
REQ-025 SHALL register pend=fifo_wr_en; in any cycle with pend=1, fifo_wr_ack=0 or fifo_overflow=1 SHALL set ack_err.
REQ-026 SHALL set ack_err when fifo_wr_ack=1 while pend=0.
REQ-027 SHALL increment wr_count on each cycle with fifo_wr_ack=1 and pend=1, holding at 16'hFFFF.
REQ-028 SHALL leave rr_ptr unchanged when there is no request or when space_ok=0.

Reset
REQ-029 SHALL, while rst=1 at a clock edge, set state=IDLE, rr_ptr=0, lock_id=0, fifo_wr_en=0, fifo_data_in=0, grant_id=0, ack_err=0, wr_count=0 and pend=0.
REQ-030 SHALL drive req_ready=0 in every cycle with rst=1.
REQ-031 SHALL, on reset during LOCKED, drop the lock with no write issued on the following cycle.

Verification
REQ-032 SHALL cover: all 4 requesters holding single-word bursts (last=1), empty FIFO -> grants 0,1,2,3,0 on consecutive cycles; fifo_wr_en high continuously.
REQ-033 SHALL cover: requester 2 sends a 3-word burst while requester 1 is valid -> words 2a,2b,2c written back-to-back; requester 1 is granted next; locked high for 2 cycles.
REQ-034 SHALL cover: FIFO at depth 8 with 6 entries, a single requester streaming -> exactly 2 writes accepted; req_ready low while fifo_full=1; overflow never asserted.
REQ-035 SHALL cover: rst asserted during LOCKED of requester 3 -> next cycle fifo_wr_en=0, locked=0, rr_ptr=0; requester 0 is granted first afterwards.
REQ-036 SHALL cover: fifo_wr_ack forced low one cycle after a write -> ack_err=1 and held until rst; wr_count not incremented.
REQ-037 SHALL cover: wr_count preset near 16'hFFFE with 3 acked writes -> wr_count reads 16'hFFFF and stays there.
